// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multi-cycle ALU with valid/ready handshakes and iterative unsigned mul/div
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALU_operation,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             zero,
  output logic             busy
);
  localparam int SW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state;

  logic [WIDTH-1:0] b_r;
  logic [3:0]       op_r;
  logic [SW-1:0]    cnt;
  logic [WIDTH-1:0] hi;   // product high half / partial remainder
  logic [WIDTH-1:0] lo;   // multiplier shifting out / quotient shifting in

  logic [SW-1:0]    sh;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   hi_n;
  logic [WIDTH-1:0] lo_n;
  logic             q_bit;
  logic [WIDTH-1:0] calc_res;

  assign sh = B[SW-1:0];

  always_comb begin
    alu_res = '0;
    case (ALU_operation)
      4'd0: alu_res = A + B;
      4'd1: alu_res = A - B;
      4'd2: alu_res = A << sh;
      4'd3: alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      4'd4: alu_res = {{(WIDTH-1){1'b0}}, (A < B)};
      4'd5: alu_res = A ^ B;
      4'd6: alu_res = A >> sh;
      4'd7: alu_res = $signed(A) >>> sh;
      4'd8: alu_res = A | B;
      4'd9: alu_res = A & B;
      default: alu_res = '0;
    endcase
  end

  // op_r[2] separates the divide pair (12,13) from the multiply pair (10,11);
  // op_r[0] selects the high/remainder half of the iteration state.
  always_comb begin
    sum   = {1'b0, hi} + (lo[0] ? {1'b0, b_r} : {(WIDTH+1){1'b0}});
    trial = {hi, lo[WIDTH-1]};
    q_bit = (trial >= {1'b0, b_r});
    if (op_r[2]) begin
      hi_n = q_bit ? (trial - {1'b0, b_r}) : trial;
      lo_n = {lo[WIDTH-2:0], q_bit};
    end else begin
      hi_n = {1'b0, sum[WIDTH:1]};
      lo_n = {sum[0], lo[WIDTH-1:1]};
    end
    calc_res = op_r[0] ? hi_n[WIDTH-1:0] : lo_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      res       <= '0;
      cnt       <= '0;
      hi        <= '0;
      lo        <= '0;
      b_r       <= '0;
      op_r      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_r <= ALU_operation;
            b_r  <= B;
            if (ALU_operation inside {[4'd10:4'd13]}) begin
              state <= CALC;
              cnt   <= SW'(WIDTH-1);
              hi    <= '0;
              lo    <= A;
            end else begin
              state     <= DONE;
              res       <= alu_res;
              out_valid <= 1'b1;
            end
          end
        end
        CALC: begin
          hi  <= hi_n[WIDTH-1:0];
          lo  <= lo_n;
          cnt <= cnt - SW'(1);
          if (cnt == '0) begin
            state     <= DONE;
            res       <= calc_res;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign zero     = (res == '0);
endmodule
